mips_multicycle: RTL

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle.sv
// mips_multicycle -- multi-cycle MIPS-subset core with a single shared
// instruction/data memory port.
//
// Supported: add, sub, and, or, slt (R-type), addi, lw, sw, beq, bne, j.
// Any other opcode, or R-type funct, stops the core in HALT until reset.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   mem_req    memory request valid (FETCH and MEM states only)
//   mem_we     request is a store
//   mem_addr   word-aligned byte address
//   mem_wdata  store data
//   mem_ready  memory accepts/completes the request this cycle
//   mem_rdata  read data, valid with mem_ready on a read
//   retire     one-cycle pulse per completed instruction
//   pc_out     fetch address of the instruction in flight
//   halted     core stopped on an illegal instruction
//   fsm_state  current control state (FETCH=0 .. HALT=5), for observation
//
// Memory handshake: a request is presented while mem_req=1 and completes in
// the cycle mem_ready=1. Address, write enable and write data only change
// after completion, so they are stable for as long as mem_ready stays low.
module mips_multicycle #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int NREGS = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [2:0]        fsm_state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state, state_next;

  // run is low for the first cycle after reset release so that mem_req
  // never asserts while reset is held.
  logic              run;
  logic [ADDR_W-1:0] pc, pc_fetch, target;
  logic [31:0]       ir, a, b, imm, aluout, mdr;
  logic [31:0]       regs [NREGS];

  // ---------------- decode ----------------
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];

  logic is_rtype, rtype_ok, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
  logic supported;
  always_comb begin
    is_rtype  = (op == OP_RTYPE);
    rtype_ok  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                (funct == FN_OR)  || (funct == FN_SLT);
    is_addi   = (op == OP_ADDI);
    is_lw     = (op == OP_LW);
    is_sw     = (op == OP_SW);
    is_beq    = (op == OP_BEQ);
    is_bne    = (op == OP_BNE);
    is_j      = (op == OP_J);
    supported = (is_rtype && rtype_ok) || is_addi || is_lw || is_sw ||
                is_beq || is_bne || is_j;
  end

  // ---------------- register read ----------------
  // R0 and specifiers beyond the implemented register count read as zero.
  logic [31:0] rs_val, rt_val;
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0 && int'(rs) < NREGS) rs_val = regs[rs];
    if (rt != 5'd0 && int'(rt) < NREGS) rt_val = regs[rt];
  end

  // ---------------- ALU ----------------
  // Non-R-type users (addi, lw/sw address) all need A + IMM.
  logic [31:0] alu_res;
  logic        zero, branch_taken;
  always_comb begin
    alu_res = a + imm;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = a + b;
      endcase
    end
  end

  assign zero         = ((a - b) == 32'd0);
  assign branch_taken = (is_beq && zero) || (is_bne && !zero);

  // Branch offset is word-scaled and relative to the already incremented PC.
  logic [31:0] br_off;
  assign br_off = {{14{ir[15]}}, ir[15:0], 2'b00};

  // Jump target keeps the top nibble of the incremented PC (32-bit view).
  logic [31:0]       pc32, jump_full;
  logic [ADDR_W-1:0] jump_tgt;
  assign pc32      = 32'(pc);
  assign jump_full = {pc32[31:28], ir[25:0], 2'b00};
  assign jump_tgt  = ADDR_W'(jump_full);

  logic [ADDR_W-1:0] ea;
  assign ea = ADDR_W'(aluout);

  // ---------------- write-back ----------------
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        wb_en;
  assign wb_dst  = is_rtype ? rd : rt;
  assign wb_data = is_lw ? mdr : aluout;
  assign wb_en   = (wb_dst != 5'd0) && (int'(wb_dst) < NREGS);

  logic unused_bits;
  assign unused_bits = ^{ea[1:0], pc32[27:0], ir[10:6]};

  // ---------------- control FSM ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = run;
        mem_addr = pc;
        if (run && mem_ready) state_next = DECODE;
      end
      DECODE: state_next = supported ? EXEC : HALT;
      EXEC: begin
        if (is_rtype || is_addi)  state_next = WB;
        else if (is_lw || is_sw)  state_next = MEM;
        else begin
          // beq / bne / j complete here
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = {ea[ADDR_W-1:2], 2'b00};
        mem_wdata = is_sw ? b : '0;
        if (mem_ready) begin
          if (is_sw) begin
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      pc_fetch <= RESET_PC;
      target   <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      imm      <= '0;
      aluout   <= '0;
      mdr      <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        FETCH: begin
          if (run && mem_ready) begin
            ir       <= mem_rdata;
            pc_fetch <= pc;
            pc       <= pc + ADDR_W'(32'd4);
          end
        end
        DECODE: begin
          a      <= rs_val;
          b      <= rt_val;
          imm    <= {{16{ir[15]}}, ir[15:0]};
          target <= pc + ADDR_W'($signed(br_off));
        end
        EXEC: begin
          aluout <= alu_res;
          if (branch_taken)  pc <= target;
          else if (is_j)     pc <= jump_tgt;
        end
        MEM: begin
          if (mem_ready && is_lw) mdr <= mem_rdata;
        end
        WB: begin
          if (wb_en) regs[wb_dst] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  assign pc_out    = (state == FETCH) ? pc : pc_fetch;
  assign halted    = (state == HALT);
  assign fsm_state = state;

endmodule
